// File: rtl/mod_reduce_p256k1_if.sv
// mod_reduce_p256k1_if: operand, busy flag and result of the p256k1 reducer
interface mod_reduce_p256k1_if;
  logic [511:0] C;
  logic         busy;
  logic [255:0] R;
  modport master (output C, input busy, R);
  modport slave  (input C, output busy, R);
endinterface

// File: rtl/mod_reduce_p256k1.sv
// mod_reduce_p256k1: reduces a 512-bit product modulo P = 2^256 - K by folding the high half with K
module mod_reduce_p256k1 #(
  parameter logic [33:0] K = 34'h1000003D1
) (
  input  logic                   clk,
  input  logic                   start,
  mod_reduce_p256k1_if.slave     bus
);
  typedef enum logic [2:0] {IDLE, LOAD, FOLD1, FOLD2, FOLD3, SUB, DONE} state_t;
  localparam logic [255:0] P = 256'(0) - 256'(K);
  state_t         state_q, state_d;
  logic [290:0]   acc_q, acc_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [255:0]   r_q, r_d;
  logic [1:0]     idx;
  logic [97:0]    limb_prod;
  logic [68:0]    hi_prod;
  logic [290:0]   fold1, fold2, fold3;
  logic [256:0]   diff;
  // each state's work is done on the edge that enters it; cnt_q names the limb already folded
  assign idx       = (state_q == LOAD) ? 2'd0 : cnt_q + 2'd1;
  assign limb_prod = 98'(bus.C[{1'b1, idx, 6'd0} +: 64]) * 98'(K);
  assign fold1     = acc_q + (291'(limb_prod) << {idx, 6'd0});
  assign hi_prod   = 69'(acc_q[290:256]) * 69'(K);
  assign fold2     = 291'(acc_q[255:0]) + 291'(hi_prod);
  assign fold3     = 291'(acc_q[255:0]) + (acc_q[256] ? 291'(K) : 291'(0));
  assign diff      = {1'b0, acc_q[255:0]} - {1'b0, P};
  assign bus.busy  = (state_q != IDLE) && (state_q != DONE);
  assign bus.R     = r_q;
  always_ff @(posedge clk or negedge start) begin
    if (!start) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      r_q     <= r_d;
    end
  end
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    r_d     = r_q;
    case (state_q)
      IDLE: begin
        state_d = LOAD;
        acc_d   = 291'(bus.C[255:0]);
        cnt_d   = '0;
      end
      LOAD: begin
        state_d = FOLD1;
        acc_d   = fold1;
      end
      FOLD1: begin
        state_d = (cnt_q == 2'd3) ? FOLD2 : FOLD1;
        acc_d   = (cnt_q == 2'd3) ? fold2 : fold1;
        cnt_d   = (cnt_q == 2'd3) ? cnt_q : cnt_q + 2'd1;
      end
      FOLD2: begin
        state_d = FOLD3;
        acc_d   = fold3;
      end
      FOLD3: begin
        state_d = SUB;
        r_d     = diff[256] ? acc_q[255:0] : diff[255:0];
      end
      SUB:     state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
endmodule
